// File: rtl/motor_pkg.sv
// motor_pkg: shared types and defaults for the dual-channel motor PWM driver.
package motor_pkg;

    // Per-channel drive state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DECEL = 2'd2,
        ST_DEAD  = 2'd3
    } chan_state_t;

    // Duty, speed and tick counter width (covers 0..PWM_STEPS, PWM_STEPS <= 127)
    localparam int DUTY_W = 7;

    localparam int PWM_STEPS_DEF    = 100;
    localparam int RAMP_STEP_DEF    = 5;
    localparam int DEAD_PERIODS_DEF = 2;

endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge channel -- drive FSM, applied duty, direction
// and the registered PWM output. Duty and direction only move on period
// boundaries. Build macro MOTOR_RAMP_EN selects gradual ramping; without it
// duty jumps straight to its goal while dead time is still enforced.
// DEAD_PERIODS must be at least 1.
module motor_channel
    import motor_pkg::*;
#(
    parameter int RAMP_STEP    = RAMP_STEP_DEF,
    parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              boundary,
    input  logic [DUTY_W-1:0] cnt_next,
    input  logic [DUTY_W-1:0] tgt_speed,
    input  logic              tgt_dir,
    output logic              pwm,
    output logic              dir,
    output logic              busy
);

`ifdef MOTOR_RAMP_EN
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);
`else
    // RAMP_STEP has no effect here; an all-ones step lets any change land in one boundary
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP) | {DUTY_W{1'b1}};
`endif
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_PERIODS - 1);

    chan_state_t       state, state_n;
    logic [DUTY_W-1:0] duty, duty_n, duty_applied;
    logic              dir_n;
    logic [7:0]        dead_cnt, dead_n;
    logic              mismatch;

    // Move cur toward tgt by at most STEP without overshooting
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        if (cur < tgt) begin
            if (tgt - cur > STEP) return cur + STEP;
            else                  return tgt;
        end else begin
            if (cur - tgt > STEP) return cur - STEP;
            else                  return tgt;
        end
    endfunction

    // A zero-speed target never forces a reversal; it just winds the duty down
    assign mismatch = (tgt_speed != '0) && (tgt_dir != dir);

    // Settled means IDLE/RUN with duty and direction already on target
    assign busy = !(((state == ST_IDLE) || (state == ST_RUN)) && (duty == tgt_speed) && !mismatch);

    // Boundary update: next state, duty, direction and dead-time count
    always_comb begin
        state_n = state;
        duty_n  = duty;
        dir_n   = dir;
        dead_n  = dead_cnt;
        case (state)
            ST_IDLE: begin
                if (tgt_speed != '0) begin
                    if (mismatch) begin
                        state_n = ST_DEAD;
                        dead_n  = '0;
                    end else begin
                        state_n = ST_RUN;
                        duty_n  = ramp_toward(duty, tgt_speed);
                    end
                end
            end
            ST_RUN: begin
                if (mismatch) begin
                    duty_n  = ramp_toward(duty, '0);
                    state_n = (duty_n == '0) ? ST_DEAD : ST_DECEL;
                    dead_n  = '0;
                end else begin
                    duty_n = ramp_toward(duty, tgt_speed);
                    if ((duty_n == '0) && (tgt_speed == '0)) state_n = ST_IDLE;
                end
            end
            ST_DECEL: begin
                if (!mismatch) begin
                    state_n = ST_RUN;
                    duty_n  = ramp_toward(duty, tgt_speed);
                end else begin
                    duty_n = ramp_toward(duty, '0);
                    if (duty_n == '0) begin
                        state_n = ST_DEAD;
                        dead_n  = '0;
                    end
                end
            end
            ST_DEAD: begin
                if (dead_cnt == DEAD_LAST) begin
                    // Dead time is always completed and the bridge always flips
                    state_n = ST_RUN;
                    dir_n   = ~dir;
                    duty_n  = (tgt_dir == ~dir) ? ramp_toward(duty, tgt_speed) : '0;
                end else begin
                    dead_n = dead_cnt + 8'd1;
                end
            end
        endcase
    end

    assign duty_applied = boundary ? duty_n : duty;

    // Channel state registers and registered PWM output
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            duty     <= '0;
            dir      <= 1'b1;
            dead_cnt <= '0;
            pwm      <= 1'b0;
        end else begin
            if (clk_en) pwm <= (cnt_next < duty_applied);
            if (boundary) begin
                state    <= state_n;
                duty     <= duty_n;
                dir      <= dir_n;
                dead_cnt <= dead_n;
            end
        end
    end

endmodule

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: two-channel H-bridge PWM driver. Holds the shared PWM tick
// counter and the command targets; each channel is a motor_channel instance.
// Build macro MOTOR_RAMP_EN enables gradual duty ramping.
module motor_pwm_drive
    import motor_pkg::*;
#(
    parameter int PWM_STEPS    = PWM_STEPS_DEF,
    parameter int RAMP_STEP    = RAMP_STEP_DEF,
    parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_left_speed,
    input  logic [DUTY_W-1:0] cmd_right_speed,
    input  logic              cmd_left_dir,
    input  logic              cmd_right_dir,
    output logic              pwm_left,
    output logic              pwm_right,
    output logic              dir_left,
    output logic              dir_right,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] LAST_TICK = DUTY_W'(PWM_STEPS - 1);
    localparam logic [DUTY_W-1:0] MAX_DUTY  = DUTY_W'(PWM_STEPS);

    logic [DUTY_W-1:0] cnt, cnt_next;
    logic              boundary, handshake;
    logic [DUTY_W-1:0] tgt_left_speed, tgt_right_speed;
    logic              tgt_left_dir, tgt_right_dir;
    logic [DUTY_W-1:0] eff_left_speed, eff_right_speed;
    logic              eff_left_dir, eff_right_dir;
    logic              busy_left, busy_right;

    function automatic logic [DUTY_W-1:0] clamp_speed(input logic [DUTY_W-1:0] s);
        return (s > MAX_DUTY) ? MAX_DUTY : s;
    endfunction

    assign cmd_ready = ~rst;
    assign handshake = cmd_valid & cmd_ready;
    assign cnt_next  = (cnt == LAST_TICK) ? '0 : cnt + 1'b1;
    assign boundary  = clk_en && (cnt == LAST_TICK);

    // A command landing on a boundary cycle is used at that boundary
    assign eff_left_speed  = handshake ? clamp_speed(cmd_left_speed)  : tgt_left_speed;
    assign eff_right_speed = handshake ? clamp_speed(cmd_right_speed) : tgt_right_speed;
    assign eff_left_dir    = handshake ? cmd_left_dir  : tgt_left_dir;
    assign eff_right_dir   = handshake ? cmd_right_dir : tgt_right_dir;

    // Tick counter, command capture (latest wins) and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            tgt_left_speed  <= '0;
            tgt_right_speed <= '0;
            tgt_left_dir    <= 1'b1;
            tgt_right_dir   <= 1'b1;
            busy            <= 1'b0;
        end else begin
            if (clk_en) cnt <= cnt_next;
            if (handshake) begin
                tgt_left_speed  <= eff_left_speed;
                tgt_right_speed <= eff_right_speed;
                tgt_left_dir    <= cmd_left_dir;
                tgt_right_dir   <= cmd_right_dir;
            end
            busy <= busy_left | busy_right;
        end
    end

    motor_channel #(.RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_left (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .boundary  (boundary),
        .cnt_next  (cnt_next),
        .tgt_speed (eff_left_speed),
        .tgt_dir   (eff_left_dir),
        .pwm       (pwm_left),
        .dir       (dir_left),
        .busy      (busy_left)
    );

    motor_channel #(.RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_right (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .boundary  (boundary),
        .cnt_next  (cnt_next),
        .tgt_speed (eff_right_speed),
        .tgt_dir   (eff_right_dir),
        .pwm       (pwm_right),
        .dir       (dir_right),
        .busy      (busy_right)
    );

endmodule

// File: tb/tb_motor_pwm_drive.sv
// tb_motor_pwm_drive: scoreboard bench. Stimulus queues the expected per-period
// high-tick count and direction of both channels; a monitor counts PWM high
// ticks over each full period and checks it against the queue.
module tb_motor_pwm_drive;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_left_speed = 7'd0;
    logic [6:0] cmd_right_speed = 7'd0;
    logic       cmd_left_dir = 1'b1;
    logic       cmd_right_dir = 1'b1;
    logic       pwm_left, pwm_right, dir_left, dir_right, busy;

    typedef struct {
        int l;
        bit ld;
        int r;
        bit rd;
    } win_t;

    win_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ticks = 0;
    int   acc_l = 0;
    int   acc_r = 0;
    logic win_dl = 1'b1;
    logic win_dr = 1'b1;

    motor_pwm_drive dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_left_speed  (cmd_left_speed),
        .cmd_right_speed (cmd_right_speed),
        .cmd_left_dir    (cmd_left_dir),
        .cmd_right_dir   (cmd_right_dir),
        .pwm_left        (pwm_left),
        .pwm_right       (pwm_right),
        .dir_left        (dir_left),
        .dir_right       (dir_right),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic ew(input int l, input bit ld, input int r, input bit rd);
        win_t e;
        e.l = l; e.ld = ld; e.r = r; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic send(input int ls, input bit ld, input int rs, input bit rd);
        @(negedge clk);
        cmd_valid       = 1'b1;
        cmd_left_speed  = 7'(ls);
        cmd_left_dir    = ld;
        cmd_right_speed = 7'(rs);
        cmd_right_dir   = rd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_ticks(input int target);
        int n;
        n = 0;
        while (ticks < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ticks < target) chk("tick_timeout", ticks, target);
    endtask

    // Clock-enable divider: one tick every 4 cycles
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            clk_en = (cyc % 4 == 0);
        end
    end

    // Monitor: one scoreboard entry per completed full PWM period
    initial begin
        win_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ticks = 0;
                acc_l = 0;
                acc_r = 0;
            end else if (clk_en) begin
                ticks++;
                if (ticks % 100 == 0) begin
                    if (ticks >= 200 && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("period_left_duty", acc_l, e.l);
                        chk("period_left_dir", int'(win_dl), int'(e.ld));
                        chk("period_right_duty", acc_r, e.r);
                        chk("period_right_dir", int'(win_dr), int'(e.rd));
                    end
                    acc_l  = 0;
                    acc_r  = 0;
                    win_dl = dir_left;
                    win_dr = dir_right;
                end
                acc_l += int'(pwm_left);
                acc_r += int'(pwm_right);
            end
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pwm_left", int'(pwm_left), 0);
        chk("reset_pwm_right", int'(pwm_right), 0);
        chk("reset_dir_left", int'(dir_left), 1);
        chk("reset_dir_right", int'(dir_right), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(cmd_ready), 1);

        // Ramp from standstill to 50 forward
        wait_ticks(100);
        send(50, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
`ifdef MOTOR_RAMP_EN
        for (int k = 1; k <= 10; k++) ew(5 * k, 1'b1, 0, 1'b1);
        ew(50, 1'b1, 0, 1'b1);
`else
        ew(50, 1'b1, 0, 1'b1);
        ew(50, 1'b1, 0, 1'b1);
`endif
        repeat (4) @(negedge clk);
        chk("busy_ramp_up", int'(busy), 1);
        drain();
        chk("busy_settled_50", int'(busy), 0);

        // Settle at 20 forward
        send(20, 1'b1, 0, 1'b1);
        ew(50, 1'b1, 0, 1'b1);
`ifdef MOTOR_RAMP_EN
        for (int k = 1; k <= 6; k++) ew(50 - 5 * k, 1'b1, 0, 1'b1);
`else
        ew(20, 1'b1, 0, 1'b1);
`endif
        ew(20, 1'b1, 0, 1'b1);
        drain();
        chk("busy_settled_20", int'(busy), 0);

        // Reverse at 20: decelerate, two dead periods, flip, ramp back up
        send(20, 1'b0, 0, 1'b1);
        ew(20, 1'b1, 0, 1'b1);
`ifdef MOTOR_RAMP_EN
        for (int k = 1; k <= 3; k++) ew(20 - 5 * k, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        for (int k = 1; k <= 4; k++) ew(5 * k, 1'b0, 0, 1'b1);
`else
        ew(0, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
`endif
        ew(20, 1'b0, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("busy_reversing", int'(busy), 1);
        drain();
        chk("busy_settled_rev", int'(busy), 0);

`ifdef MOTOR_RAMP_EN
        // Reverse, then restore the original direction while still decelerating
        send(20, 1'b1, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        ew(15, 1'b0, 0, 1'b1);
        drain();
        chk("busy_decel", int'(busy), 1);
        send(20, 1'b0, 0, 1'b1);
        ew(10, 1'b0, 0, 1'b1);
        ew(15, 1'b0, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        drain();
        chk("busy_restored", int'(busy), 0);
`else
        // Reverse, then restore the original direction during dead time:
        // dead time completes and the bridge flips anyway, then flips back
        send(20, 1'b1, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        ew(0, 1'b0, 0, 1'b1);
        drain();
        chk("busy_dead", int'(busy), 1);
        send(20, 1'b0, 0, 1'b1);
        ew(0, 1'b0, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
        drain();
        chk("busy_restored", int'(busy), 0);
`endif

        // Over-range speed on the right channel is clamped to full duty
        send(20, 1'b0, 127, 1'b1);
        ew(20, 1'b0, 0, 1'b1);
`ifdef MOTOR_RAMP_EN
        for (int k = 1; k <= 20; k++) ew(20, 1'b0, 5 * k, 1'b1);
`else
        ew(20, 1'b0, 100, 1'b1);
`endif
        ew(20, 1'b0, 100, 1'b1);
        drain();
        chk("busy_clamped", int'(busy), 0);

        // Reverse the left channel and reset in the middle of its dead time
        send(20, 1'b1, 127, 1'b1);
        ew(20, 1'b0, 100, 1'b1);
`ifdef MOTOR_RAMP_EN
        for (int k = 1; k <= 3; k++) ew(20 - 5 * k, 1'b0, 100, 1'b1);
`endif
        ew(0, 1'b0, 100, 1'b1);
        drain();
        chk("busy_mid_dead", int'(busy), 1);
        chk("dir_left_mid_dead", int'(dir_left), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pwm_left", int'(pwm_left), 0);
        chk("rst_pwm_right", int'(pwm_right), 0);
        chk("rst_dir_left", int'(dir_left), 1);
        chk("rst_dir_right", int'(dir_right), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_pulse", int'(cmd_ready), 1);

        // Step command 0 -> 80 after reset
        wait_ticks(100);
        send(80, 1'b1, 0, 1'b1);
        ew(0, 1'b1, 0, 1'b1);
`ifdef MOTOR_RAMP_EN
        ew(5, 1'b1, 0, 1'b1);
        ew(10, 1'b1, 0, 1'b1);
        ew(15, 1'b1, 0, 1'b1);
`else
        ew(80, 1'b1, 0, 1'b1);
        ew(80, 1'b1, 0, 1'b1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
